// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  // Access types in RV32 load/store func3 encoding
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int DEFAULT_TIMEOUT_CYC = 64;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-state watchdog: down-counter loaded on grant, expired at terminal count.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] r_count;
  logic          r_run;

  // Loaded with TIMEOUT_CYC-1 so terminal count lands on the TIMEOUT_CYC-th busy cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_run   <= 1'b0;
    end else if (start) begin
      r_count <= CW'(TIMEOUT_CYC - 1);
      r_run   <= 1'b1;
    end else if (clear) begin
      r_run   <= 1'b0;
    end else if (r_run && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = r_run && (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/ack memory port between instruction fetch and load/store.
// Optional busy-state timeout with error completion when ARB_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no transaction outstanding; grants are combinational
// ST_BUSY_IF | fetch transaction on the memory port
// ST_BUSY_DM | load/store transaction on the memory port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int Inst_Size   = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [Inst_Size-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [Inst_Size-1:0] if_rdata,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [Inst_Size-1:0] dm_addr,
  input  logic [Inst_Size-1:0] dm_wdata,
  input  logic [2:0]           dm_type,
  output logic                 dm_gnt,
  output logic                 dm_rvalid,
  output logic [Inst_Size-1:0] dm_rdata,
  output logic                 err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [Inst_Size-1:0] mem_addr,
  output logic [Inst_Size-1:0] mem_wdata,
  output logic [2:0]           mem_type,
  input  logic                 mem_ack,
  input  logic [Inst_Size-1:0] mem_rdata
);

  arb_state_t           r_state;
  req_id_t              r_last_gnt;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [Inst_Size-1:0] r_mem_addr;
  logic [Inst_Size-1:0] r_mem_wdata;
  logic [2:0]           r_mem_type;
  logic                 r_if_rvalid;
  logic                 r_dm_rvalid;
  logic [Inst_Size-1:0] r_if_rdata;
  logic [Inst_Size-1:0] r_dm_rdata;

  logic w_idle;
  logic w_pick_dm;
  logic w_pick_if;
  logic w_abort;

  // On a tie the requester that did not win last time gets the port
  assign w_idle    = (r_state == ST_IDLE);
  assign w_pick_dm = dm_req && (!if_req || (r_last_gnt == REQ_IF));
  assign w_pick_if = if_req && !w_pick_dm;
  assign if_gnt    = w_idle && w_pick_if;
  assign dm_gnt    = w_idle && w_pick_dm;

`ifdef ARB_TIMEOUT_EN
  logic w_expired;
  logic w_wd_clear;
  logic r_err;

  assign w_wd_clear = !w_idle && (mem_ack || w_expired);

  arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (if_gnt || dm_gnt),
    .clear   (w_wd_clear),
    .expired (w_expired)
  );

  // An ack arriving on the expiry cycle still completes normally
  assign w_abort = w_expired && !mem_ack;
  assign err     = r_err;
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last_gnt  <= REQ_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_type  <= '0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_pick_dm) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_mem_type  <= dm_type;
            r_last_gnt  <= REQ_DM;
            r_state     <= ST_BUSY_DM;
          end else if (w_pick_if) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_type  <= F3_LW;
            r_last_gnt  <= REQ_IF;
            r_state     <= ST_BUSY_IF;
          end
        end
        ST_BUSY_IF: begin
          if (mem_ack || w_abort) begin
            r_mem_req   <= 1'b0;
            r_if_rvalid <= 1'b1;
            r_if_rdata  <= mem_ack ? mem_rdata : '0;
            r_state     <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
            r_err       <= w_abort;
`endif
          end
        end
        ST_BUSY_DM: begin
          if (mem_ack || w_abort) begin
            r_mem_req   <= 1'b0;
            r_dm_rvalid <= 1'b1;
            r_dm_rdata  <= (mem_ack && !r_mem_we) ? mem_rdata : '0;
            r_state     <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
            r_err       <= w_abort;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_type  = r_mem_type;
  assign if_rvalid = r_if_rvalid;
  assign dm_rvalid = r_dm_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares one external memory port between the instruction-fetch path and the load/store path of the RV32IM core. It accepts requests from both, grants one at a time, and drives a single request/acknowledge memory interface. It returns read data or write completion to the granted requester. It sits between the IF/memory-access stages and the memory model, and lets fetch and data share a single-ported memory.

## Interface
- `Inst_Size`, 32, data and address width.
- `TIMEOUT_CYC`, 64, cycles in a busy state before abort. Used only with `ARB_TIMEOUT_EN`; minimum 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  Inst_Size  fetch address (word access).
- `if_gnt`  out  1  one-cycle pulse; the fetch request is accepted.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` is valid.
- `if_rdata`  out  Inst_Size  fetched word.
- `dm_req`  in  1  data request; held until `dm_gnt`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`, `dm_wdata`  in  Inst_Size  data address and store data.
- `dm_type`  in  3  access type, using the func3 encoding (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `dm_gnt`, `dm_rvalid`  out  1  same meaning as the fetch signals.
- `dm_rdata`  out  Inst_Size  load data; 0 on store completion.
- `err`  out  1  accompanies an `*_rvalid` pulse when the transaction aborted.
- `mem_req`  out  1  memory request; held high until `mem_ack`.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_type`  out  —  registered request fields; stable while `mem_req` is high.
- `mem_ack`  in  1  one-cycle completion from memory.
- `mem_rdata`  in  Inst_Size  read data, valid with `mem_ack`.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE behaviour:
  - Only fetch pending: grant fetch, go to BUSY_IF.
  - Only data pending: grant data, go to BUSY_DM.
  - Both pending: grant the requester that was not granted last (`last_gnt` flag). After reset `last_gnt` = fetch, so data wins the first tie.
- On grant:
  - The `*_gnt` pulse is combinational in IDLE, in the same cycle as the request.
  - Request fields are latched into the `mem_*` registers.
  - `last_gnt` is updated.
- BUSY_x: `mem_req` = 1 until `mem_ack`. On ack:
  - Capture `mem_rdata` (or 0 for a store).
  - Pulse the matching `*_rvalid` on the next cycle.
  - Clear `mem_req`.
  - Return to IDLE.
- Fetch always issues `mem_we` = 0 and `mem_type` = LW.
- `mem_ack` while in IDLE is ignored. No spurious `rvalid`.
- A requester dropping `*_req` before its grant is legal; nothing is issued for it.
- At most one outstanding memory transaction at any time.

## Timing
- Reset (asynchronous): state = IDLE, `last_gnt` = fetch. All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_type`, both `gnt`, both `rvalid`, both `rdata`, `err`.
- Reset mid-transaction: the transaction is dropped with no `rvalid`. A late `mem_ack` after reset is ignored.
- Cycle sequence for a memory that acks k cycles after `mem_req` rises:
  - Request and grant at cycle 0.
  - `mem_req` high from cycle 1 through cycle k.
  - `rvalid` pulses at cycle k+1.
  - The next grant can also occur at cycle k+1.
- Minimum service time: k = 1 gives 2 cycles per transaction.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A watchdog counts cycles in BUSY_x.
  - If it reaches `TIMEOUT_CYC` without `mem_ack`: drop `mem_req`, pulse `*_rvalid` with `err` = 1 and `rdata` = 0, go to IDLE.
  - A simultaneous ack on the timeout cycle wins; it completes normally with `err` = 0.
- `ARB_TIMEOUT_EN` undefined: no counter; `err` is tied to 0; a busy state waits indefinitely.

## Structure
- Package `mem_arb_pkg`:
  - FSM state enum.
  - Requester-id typedef (`REQ_IF`, `REQ_DM`).
  - `dm_type` func3 constants.
  - Default `TIMEOUT_CYC`.
- One sub-module, `arb_watchdog`: loadable cycle counter with `start`, `clear` and `expired` signals, instantiated only under `ARB_TIMEOUT_EN`.

## Test plan
- Fetch only, `if_addr` = 0x100, memory acks after 1 cycle with 0x00500093 -> `if_gnt` at cycle 0, `mem_req` at cycle 1, `if_rvalid` with `if_rdata` = 0x00500093 at cycle 2.
- Fetch and data both requested at cycle 0 after reset, store SW of 0xDEADBEEF to 0x200 -> data is granted first, `dm_rvalid` with `dm_rdata` = 0. The fetch is granted in the same cycle as `dm_rvalid`.
- Both requesters held continuously for 6 transactions -> grants alternate DM, IF, DM, IF, DM, IF.
- Load LBU from 0x203, ack latency 4 -> `mem_type` = 3'b100 and `mem_addr` stay stable for 4 cycles; `dm_rvalid` 5 cycles after grant.
- `reset` asserted while in BUSY_DM, with `mem_ack` one cycle after release -> all outputs 0; no `rvalid` ever pulses.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYC` = 8, memory never acks -> `mem_req` drops after 8 cycles, `if_rvalid` = 1 with `err` = 1, FSM back in IDLE.
